mem_array_summer: RTL
=====================

// Module: mem_array_summer
// PURPOSE
//  Memory-side initiator for the single-port 256x16 data memory (async read, write on posedge clk).
//  On start, reads a length word at base_addr and that many elements that follow it, then
//  accumulates a 16-bit sum. Optionally writes the sum back to memory right after the array.
//  Lets the datapath offload the array-sum kernel; it owns the memory port while busy.
// PARAMETERS
//  ADDR_W     8    memory address width (word addressed)
//  DATA_W     16   memory data width and accumulator width
//  MAX_COUNT  255  length words above this are clamped to MAX_COUNT
// PORTS
//  clk        in   1       single clock, all state updates on posedge
//  rst        in   1       synchronous, active-high reset
//  start      in   1       one-cycle request; sampled only in IDLE
//  base_addr  in   ADDR_W  address of the length word; captured on accepted start
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_wr     out  1       memory write enable
//  mem_rdata  in   DATA_W  memory read data, valid in the same cycle as mem_addr
//  busy       out  1       high from the cycle after an accepted start until done
//  done       out  1       one-cycle pulse when the result is final
//  sum        out  DATA_W  result register; holds its value until the next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; mem_addr=0, mem_wdata=0, mem_wr=0, busy=0, done=0, sum=0.
//  All outputs are registered or decoded from state only; no comb path from mem_rdata to outputs.
//  FSM: IDLE -> LDCNT -> ACC -> [STORE] -> FIN -> IDLE.
//   IDLE : start=1 latches base, clears acc and idx, and goes to LDCNT. Otherwise stays.
//   LDCNT: mem_addr=base. cnt=min(mem_rdata, MAX_COUNT).
//          cnt==0 goes to STORE (macro on) or FIN (macro off). Otherwise idx=1 and goes to ACC.
//   ACC  : mem_addr=base+idx. acc+=mem_rdata. idx++.
//          After idx==cnt, goes to STORE (macro on) or FIN (macro off).
//   STORE: mem_addr=base+cnt+1, mem_wdata=acc, mem_wr=1 for exactly this one cycle.
//   FIN  : sum<=acc, done=1 for one cycle, busy=0 on the following cycle, then IDLE.
//  Arithmetic rules:
//   - All address sums are modulo 2^ADDR_W (base=250, cnt=10 wraps to addresses 251..4).
//   - acc is modulo 2^DATA_W; overflow silently wraps.
//  Latency from start accepted to done: cnt+3 cycles with the macro on, cnt+2 without.
//  In IDLE, mem_wr=0 and mem_addr holds its last value.
//  Boundary and concurrency rules:
//   - start while busy: ignored, never queued.
//   - start in the FIN cycle: ignored.
//   - rst mid-operation: back to IDLE next cycle, mem_wr=0, no partial write, sum=0.
//   - Writing into the array region itself (base+cnt+1 wraps onto an input address) is allowed;
//     the elements are already read by then.
// CONFIGURATION
//  ARRSUM_WRITEBACK_EN defined  : STORE state is present; the sum is written to base+cnt+1.
//  ARRSUM_WRITEBACK_EN undefined: STORE is removed; mem_wr is tied 0 and mem_wdata is tied 0.
//   Result is available on sum only.
// TESTING
//  T1: mem[48]=11, mem[49..59]=1..11, start with base=48.
//      -> sum=0x0042, done at cycle 14; with the macro, mem[60]=0x0042 and mem_wr pulsed once.
//  T2: mem[16]=0, start with base=16.
//      -> sum=0, done at cycle 3 (macro) or 2; with the macro, mem[17]=0.
//  T3: mem[10]=2, mem[11]=0xFFFF, mem[12]=0x0003, start with base=10 -> sum=0x0002 (wrap).
//  T4: base=0xFE, mem[0xFE]=3, mem[0xFF]=1, mem[0x00]=2, mem[0x01]=4.
//      -> sum=7; with the macro, write lands at address 0x02.
//  T5: pulse start again during ACC of T1 -> ignored, T1 result unchanged, single done pulse.
//  T6: assert rst during ACC of T1 -> IDLE, sum=0, busy=0, mem[60] unchanged.
//      A fresh start afterwards gives 0x0042.

Source files
------------

// File: rtl/mem_array_summer.sv
// Array-sum initiator: reads a length word at base_addr, sums the following elements.
// Define ARRSUM_WRITEBACK_EN to also store the sum to memory right after the array.
module mem_array_summer #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int MAX_COUNT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] sum
);

`ifdef ARRSUM_WRITEBACK_EN
    typedef enum logic [2:0] {IDLE, LDCNT, ACC, STORE, FIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, LDCNT, ACC, FIN} state_t;
`endif

    localparam logic [DATA_W-1:0] MAX_CNT = DATA_W'(MAX_COUNT);

    state_t            state_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [DATA_W-1:0] cnt_reg;
    logic [DATA_W-1:0] idx_reg;
    logic [DATA_W-1:0] acc_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [DATA_W-1:0] sum_reg;

    logic [DATA_W-1:0] cnt_next;
    logic [DATA_W-1:0] acc_next;
    logic [DATA_W-1:0] tail_sum;
    logic [ADDR_W-1:0] addr_next;
    logic              enter_tail;

    // base+idx+1 serves both as the next element address and, once idx==cnt,
    // as the write-back address (idx is 0 in LDCNT, so cnt==0 also lands on base+1).
    always_comb begin
        cnt_next   = (mem_rdata > MAX_CNT) ? MAX_CNT : mem_rdata;
        acc_next   = acc_reg + mem_rdata;
        tail_sum   = (state_reg == ACC) ? acc_next : acc_reg;
        addr_next  = base_reg + ADDR_W'(idx_reg) + ADDR_W'(1);
        enter_tail = ((state_reg == LDCNT) && (cnt_next == '0)) ||
                     ((state_reg == ACC) && (idx_reg == cnt_reg));
    end

`ifdef ARRSUM_WRITEBACK_EN
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              mem_wr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wr    = mem_wr_reg;
`else
    assign mem_wdata = '0;
    assign mem_wr    = 1'b0;
`endif

    assign mem_addr = mem_addr_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign sum      = sum_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            base_reg      <= '0;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            acc_reg       <= '0;
            mem_addr_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            sum_reg       <= '0;
`ifdef ARRSUM_WRITEBACK_EN
            mem_wdata_reg <= '0;
            mem_wr_reg    <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
`ifdef ARRSUM_WRITEBACK_EN
            mem_wr_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        base_reg     <= base_addr;
                        acc_reg      <= '0;
                        idx_reg      <= '0;
                        mem_addr_reg <= base_addr;
                        busy_reg     <= 1'b1;
                        state_reg    <= LDCNT;
                    end
                end
                LDCNT, ACC: begin
                    if (state_reg == LDCNT) begin
                        cnt_reg <= cnt_next;
                    end else begin
                        acc_reg <= acc_next;
                    end
                    if (enter_tail) begin
`ifdef ARRSUM_WRITEBACK_EN
                        state_reg     <= STORE;
                        mem_addr_reg  <= addr_next;
                        mem_wdata_reg <= tail_sum;
                        mem_wr_reg    <= 1'b1;
`else
                        state_reg <= FIN;
                        done_reg  <= 1'b1;
                        sum_reg   <= tail_sum;
`endif
                    end else begin
                        idx_reg      <= idx_reg + DATA_W'(1);
                        mem_addr_reg <= addr_next;
                        state_reg    <= ACC;
                    end
                end
`ifdef ARRSUM_WRITEBACK_EN
                STORE: begin
                    state_reg <= FIN;
                    done_reg  <= 1'b1;
                    sum_reg   <= acc_reg;
                end
`endif
                FIN: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
